pwm_generator: RTL and testbench
================================

PWM_GENERATOR -- requirements
Module: pwm_generator

Interface
REQ-001 The block SHALL have parameter PRESCALE_DIV, default 12, giving the clk cycles per PWM counter step (legal range 1..65535).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port en_reg_out_7_0, input, 8 bits: output enables for channels 7..0.
REQ-005 The block SHALL have port en_reg_out_15_8, input, 8 bits: output enables for channels 15..8.
REQ-006 The block SHALL have port en_reg_pwm_7_0, input, 8 bits: PWM mode selects for channels 7..0.
REQ-007 The block SHALL have port en_reg_pwm_15_8, input, 8 bits: PWM mode selects for channels 15..8.
REQ-008 The block SHALL have port pwm_duty_cycle, input, 8 bits: requested duty, shared by all channels.
REQ-009 The block SHALL have port out, output, 16 bits: registered channel outputs, bit i is channel i.
REQ-010 The block SHALL have port period_start, output, 1 bit: one-clk pulse marking the first step of each PWM period.

Function
REQ-011 The prescaler SHALL count 0..PRESCALE_DIV-1 and then wrap; tick is asserted for one clk when it is PRESCALE_DIV-1; with PRESCALE_DIV=1, tick SHALL be high every cycle.
REQ-012 The 8-bit period counter pwm_cnt SHALL increment only on tick, wrapping 255->0, so one period is 256*PRESCALE_DIV clk.
REQ-013 The duty shadow register duty_sh SHALL load pwm_duty_cycle only on the cycle where tick is high and pwm_cnt=255, so duty changes take effect at period boundaries only.
REQ-014 period_start SHALL be high exactly on the cycle in which duty_sh reloads.
REQ-015 pwm_level SHALL be 1 when duty_sh=255, and otherwise (pwm_cnt < duty_sh); duty_sh=0 therefore gives a constant 0.
REQ-016 Next out[i] SHALL be: 0 if the enable bit is 0; 1 if the enable bit is 1 and the mode bit is 0; pwm_level if both bits are 1.
REQ-017 out SHALL be registered, one clk after the inputs and counters it is computed from.
REQ-018 Enable and mode register changes SHALL affect out on the next clk, without waiting for a period boundary.
REQ-019 Over a 256-step period, a PWM-mode channel SHALL be high for exactly duty_sh steps (0..254), or all 256 steps when duty_sh is 255.
REQ-020 If a duty write and a period boundary occur in the same cycle, the block SHALL sample the new value in that cycle.
REQ-021 The counter SHALL be free-running, with no dependence on SPI activity.

Reset
REQ-022 While rst is 1, the block SHALL hold prescaler=0, pwm_cnt=0, duty_sh=0, out=16'h0000 and period_start=0.
REQ-023 Assertion of rst mid-period SHALL force out low immediately (asynchronously).
REQ-024 After rst is released, counting SHALL start from 0; the first period runs with duty_sh=0 until the first boundary.

Structure
REQ-025 Package pwm_pkg SHALL hold PWM_CNT_W=8, PWM_CHANNELS=16, the default PRESCALE_DIV, and the duty constants DUTY_OFF=0 and DUTY_FULL=255.
REQ-026 The prescaler SHALL be a sub-module, pwm_prescaler (parameter DIV; ports clk, rst, tick); counter, shadow and output logic SHALL stay in the top level.

Verification
REQ-027 Bench scenario, PRESCALE_DIV=1, all enables 1, modes 0: out=16'hFFFF one clk after rst release; then clear en_reg_out_15_8 -> out=16'h00FF on the next clk.
REQ-028 Bench scenario, PRESCALE_DIV=1, all PWM, duty=128 before the first boundary: in every period after the first boundary, out is FFFF for 128 clk and then 0000 for 128 clk.
REQ-029 Bench scenario, duty=0 -> PWM channels always 0; duty=255 -> PWM channels always 1 over 512 clk.
REQ-030 Bench scenario, PRESCALE_DIV=12, duty changed 64->192 mid-period: the high time stays 64*12 clk until the next period_start, then becomes 192*12 clk; the period_start spacing is 3072 clk.
REQ-031 Bench scenario, mixed config en_out=16'hA5A5, en_pwm=16'h0F0F, duty=32: static-high channels are A0A0, PWM channels are 0505, disabled channels are 0.
REQ-032 Bench scenario, rst asserted during the PWM-high phase: out=0 within the same cycle; after release, period_start is first seen after 256*PRESCALE_DIV clk.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared widths, channel count and duty constants for the PWM generator.
package pwm_pkg;

    localparam int PWM_CNT_W            = 8;
    localparam int PWM_CHANNELS         = 16;
    localparam int PRESCALE_DIV_DEFAULT = 12;

    localparam logic [PWM_CNT_W-1:0] DUTY_OFF  = 8'd0;
    localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'd255;
    localparam logic [PWM_CNT_W-1:0] CNT_MAX   = 8'd255;

    // PWM comparator: full duty is forced high so every one of the 256 steps is covered.
    function automatic logic pwm_level_f(input logic [PWM_CNT_W-1:0] cnt,
                                         input logic [PWM_CNT_W-1:0] duty);
        if (duty == DUTY_FULL) begin
            return 1'b1;
        end
        return (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: counts 0..DIV-1 and flags the last count with a one-clk tick.
// With DIV=1 the counter stays at 0 and tick is high every cycle.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int DIV = PRESCALE_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(DIV - 1);

    logic [15:0] cnt;

    // Free-running divider count, wrapping after the last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 16'd0;
        end else if (cnt == LAST) begin
            cnt <= 16'd0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/pwm_generator.sv
// 16-channel PWM generator with a shared duty cycle.
// Duty is shadowed and only reloaded at period boundaries; enable and mode
// selects act on the next clock. Outputs are registered.
module pwm_generator
    import pwm_pkg::*;
#(
    parameter int PRESCALE_DIV = PRESCALE_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    logic                    tick;
    logic                    boundary;
    logic                    pwm_level;
    logic [PWM_CNT_W-1:0]    pwm_cnt;
    logic [PWM_CNT_W-1:0]    duty_sh;
    logic [PWM_CHANNELS-1:0] en_out;
    logic [PWM_CHANNELS-1:0] en_pwm;
    logic [PWM_CHANNELS-1:0] out_next;

    pwm_prescaler #(
        .DIV (PRESCALE_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign en_out    = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm    = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign boundary  = tick && (pwm_cnt == CNT_MAX);
    assign pwm_level = pwm_level_f(pwm_cnt, duty_sh);

    // Period counter advances one step per prescaler tick, wrapping 255 -> 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    // Duty shadow reloads only at the period boundary; period_start marks the reload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_sh      <= DUTY_OFF;
            period_start <= 1'b0;
        end else begin
            period_start <= boundary;
            if (boundary) begin
                duty_sh <= pwm_duty_cycle;
            end
        end
    end

    // Per-channel select: disabled -> 0, static mode -> 1, PWM mode -> pwm_level.
    always_comb begin
        out_next = '0;
        for (int i = 0; i < PWM_CHANNELS; i++) begin
            if (en_out[i]) begin
                out_next[i] = en_pwm[i] ? pwm_level : 1'b1;
            end
        end
    end

    // Registered channel outputs; reset clears them asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= '0;
        end else begin
            out <= out_next;
        end
    end

endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator: one instance with PRESCALE_DIV=1 and one
// with PRESCALE_DIV=12 share the same stimulus.
module tb_pwm_generator;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;
    logic [15:0] out1;
    logic [15:0] out12;
    logic        ps1;
    logic        ps12;

    int n_checks = 0;
    int n_fail   = 0;

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    pwm_generator #(.PRESCALE_DIV(1)) dut1 (
        .clk             (clk),
        .rst             (rst),
        .en_reg_out_7_0  (en_out[7:0]),
        .en_reg_out_15_8 (en_out[15:8]),
        .en_reg_pwm_7_0  (en_pwm[7:0]),
        .en_reg_pwm_15_8 (en_pwm[15:8]),
        .pwm_duty_cycle  (duty),
        .out             (out1),
        .period_start    (ps1)
    );

    pwm_generator #(.PRESCALE_DIV(12)) dut12 (
        .clk             (clk),
        .rst             (rst),
        .en_reg_out_7_0  (en_out[7:0]),
        .en_reg_out_15_8 (en_out[15:8]),
        .en_reg_pwm_7_0  (en_pwm[7:0]),
        .en_reg_pwm_15_8 (en_pwm[15:8]),
        .pwm_duty_cycle  (duty),
        .out             (out12),
        .period_start    (ps12)
    );

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance negedge by negedge until period_start of the chosen instance; -1 on timeout.
    task automatic wait_ps(input bit slow, input int max_cyc, output int waited);
        waited = -1;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            if ((slow ? ps12 : ps1) === 1'b1) begin
                waited = k;
                break;
            end
        end
    endtask

    // DIV=1 period: out1 must be hi for the first hi_len cycles then lo; ps1 only on the last cycle.
    task automatic measure1(input int len, input logic [15:0] hi, input logic [15:0] lo,
                            input int hi_len, output int bad);
        bad = 0;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (out1 !== ((k <= hi_len) ? hi : lo)) bad++;
            if (ps1 !== (k == len)) bad++;
        end
    endtask

    // DIV=12 period: out12 high for exp_hi cycles; optional duty change at change_at.
    task automatic measure12(input int len, input int exp_hi, input int change_at,
                             input logic [7:0] new_duty, output int bad);
        bad = 0;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (k == change_at) duty = new_duty;
            if (out12 !== ((k <= exp_hi) ? 16'hFFFF : 16'h0000)) bad++;
            if (ps12 !== (k == len)) bad++;
        end
    endtask

    initial begin
        int w;
        int bad;
        int first1;
        int first12;

        // Reset state.
        rst    = 1'b1;
        en_out = 16'h0000;
        en_pwm = 16'h0000;
        duty   = 8'd0;
        repeat (3) @(negedge clk);
        check16("rst_out1", out1, 16'h0000);
        check16("rst_out12", out12, 16'h0000);
        check16("rst_ps1", {15'd0, ps1}, 16'h0000);
        check16("rst_ps12", {15'd0, ps12}, 16'h0000);

        // Static mode, all enabled; then drop the upper byte.
        en_out = 16'hFFFF;
        duty   = 8'd128;
        rst    = 1'b0;
        @(negedge clk);
        check16("static_all_out1", out1, 16'hFFFF);
        check16("static_all_out12", out12, 16'hFFFF);
        en_out = 16'h00FF;
        @(negedge clk);
        check16("static_low_byte", out1, 16'h00FF);

        // All PWM: the first period runs with duty_sh=0.
        en_out = 16'hFFFF;
        en_pwm = 16'hFFFF;
        @(negedge clk);
        check16("first_period_off1", out1, 16'h0000);
        check16("first_period_off12", out12, 16'h0000);
        wait_ps(1'b0, 300, w);
        check_int("first_ps1_delay", w, 253);

        // duty=128: 128 high then 128 low, two periods.
        measure1(256, 16'hFFFF, 16'h0000, 128, bad);
        check_int("duty128_p1", bad, 0);
        measure1(256, 16'hFFFF, 16'h0000, 128, bad);
        check_int("duty128_p2", bad, 0);

        // duty=0 gives constant low over 512 clk.
        duty = 8'd0;
        wait_ps(1'b0, 300, w);
        check_int("duty0_ps", w, 256);
        measure1(256, 16'hFFFF, 16'h0000, 0, bad);
        check_int("duty0_p1", bad, 0);
        measure1(256, 16'hFFFF, 16'h0000, 0, bad);
        check_int("duty0_p2", bad, 0);

        // duty=255 gives constant high over 512 clk.
        duty = 8'd255;
        wait_ps(1'b0, 300, w);
        check_int("duty255_ps", w, 256);
        measure1(256, 16'hFFFF, 16'h0000, 256, bad);
        check_int("duty255_p1", bad, 0);
        measure1(256, 16'hFFFF, 16'h0000, 256, bad);
        check_int("duty255_p2", bad, 0);

        // Mixed config: enables/modes act on the next clk, duty at the boundary.
        en_out = 16'hA5A5;
        en_pwm = 16'h0F0F;
        duty   = 8'd32;
        @(negedge clk);
        check16("mixed_immediate", out1, 16'hA5A5);
        wait_ps(1'b0, 300, w);
        check_int("mixed_ps", w, 255);
        measure1(256, 16'hA5A5, 16'hA0A0, 32, bad);
        check_int("mixed_duty32", bad, 0);

        // Duty written in the boundary cycle itself is the one sampled.
        duty = 8'd200;
        repeat (255) @(negedge clk);
        duty = 8'd16;
        @(negedge clk);
        check16("boundary_ps", {15'd0, ps1}, 16'h0001);
        measure1(256, 16'hA5A5, 16'hA0A0, 16, bad);
        check_int("boundary_write_duty16", bad, 0);

        // DIV=12: duty 64 -> 192 mid-period, change visible only next period.
        en_out = 16'hFFFF;
        en_pwm = 16'hFFFF;
        duty   = 8'd64;
        wait_ps(1'b1, 3100, w);
        check_int("div12_ps_found", (w > 0) ? 1 : 0, 1);
        measure12(3072, 768, 1000, 8'd192, bad);
        check_int("div12_duty64", bad, 0);
        measure12(3072, 2304, 0, 8'd192, bad);
        check_int("div12_duty192", bad, 0);

        // Reset during the high phase clears outputs without waiting for a clock.
        repeat (100) @(negedge clk);
        check16("pre_rst_high12", out12, 16'hFFFF);
        #2 rst = 1'b1;
        #1;
        check16("async_rst_out12", out12, 16'h0000);
        check16("async_rst_out1", out1, 16'h0000);
        @(negedge clk);
        rst     = 1'b0;
        first1  = -1;
        first12 = -1;
        for (int k = 1; k <= 3100; k++) begin
            @(negedge clk);
            if (ps1 === 1'b1 && first1 < 0) first1 = k;
            if (ps12 === 1'b1 && first12 < 0) begin
                first12 = k;
                break;
            end
        end
        check_int("post_rst_ps1", first1, 256);
        check_int("post_rst_ps12", first12, 3072);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
